// File: rtl/offset_decoder_if.sv
// Handshake bundle between an offset-encoded producer, the decoder FIFO and its consumer.
// slave is the decoder's view; master is the producer/consumer side.
interface offset_decoder_if #(
  parameter int WIDTH = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_val;
  logic             in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [7:0]       out_count;

  modport slave (
    input  in_valid, in_val, in_sel, out_ready,
    output in_ready, out_valid, out_val, out_count
  );

  modport master (
    output in_valid, in_val, in_sel, out_ready,
    input  in_ready, out_valid, out_val, out_count
  );
endinterface

// File: rtl/offset_decoder.sv
// Removes a selectable fixed offset (mod 2^WIDTH) from incoming words and queues the
// decoded results in a circular-buffer FIFO; also counts delivered words (wraps at 256).
module offset_decoder #(
  parameter int WIDTH    = 3,
  parameter int DEPTH    = 4,
  parameter int OFFSET_A = 7,
  parameter int OFFSET_B = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  offset_decoder_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  // Truncation to WIDTH bits is exactly the mod 2^WIDTH reduction of each offset.
  localparam logic [WIDTH-1:0] W_OFF_A  = WIDTH'(OFFSET_A);
  localparam logic [WIDTH-1:0] W_OFF_B  = WIDTH'(OFFSET_B);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic [7:0]       r_out_count;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_dec;

  // Readiness comes only from registered occupancy, so out_ready never reaches in_ready.
  assign w_in_ready  = (r_count != FULL_CNT);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_dec       = bus.in_val - (bus.in_sel ? W_OFF_B : W_OFF_A);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_val   = r_mem[r_rd_ptr];
  assign bus.out_count = r_out_count;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_out_count <= r_out_count + 8'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; entries are only reachable through the reset pointers.
  always_ff @(posedge clock) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= w_dec;
    end
  end

endmodule
